board_draw_sched: RTL
=====================

Name: board_draw_sched

Overview:
- Sequences the 64x24 box renderer to paint the Tetris playfield, which is 10 columns x 20 rows and exactly covers 640x480.
- Serves two kinds of request:
  - full-board redraw, walking every cell of the board RAM;
  - single-cell update, painting one cell from a request.
- Sits between game logic/board RAM and the box renderer. It drives the renderer's start/x0/y0/color and consumes its done.

Parameters:
- COLS, 10, playfield columns
- ROWS, 20, playfield rows
- CELL_W, 64, cell width in pixels
- CELL_H, 24, cell height in pixels
- ADDR_W, 8, board RAM address width (COLS*ROWS ≤ 2^ADDR_W)

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- redraw  in  1  full-board redraw request; level or pulse, sampled each cycle
- upd_valid  in  1  single-cell update request
- upd_ready  out  1  update accepted this cycle (valid&&ready)
- upd_col  in  4  update column, 0..COLS-1
- upd_row  in  5  update row, 0..ROWS-1
- upd_type  in  3  cell type for update
- cell_addr  out  ADDR_W  board RAM read address = row*COLS+col
- cell_rd  out  1  board RAM read strobe
- cell_data  in  3  board RAM data, valid exactly 1 cycle after cell_rd
- box_start  out  1  one-cycle start pulse to renderer
- box_x0  out  10  cell top-left X
- box_y0  out  9  cell top-left Y
- box_color  out  9  RRR_GGG_BBB
- box_done  in  1  renderer completion pulse
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after the last cell of a full redraw

Behaviour:
- Reset values: all outputs 0; state IDLE; redraw_pending 0; row/col counters 0.
- Palette (type→color):
  - 0→9'h000
  - 1→9'h03F
  - 2→9'h1F8
  - 3→9'h147
  - 4→9'h038
  - 5→9'h1C0
  - 6→9'h007
  - 7→9'h1E0
- Coordinates are computed from the row/col counters: box_x0=col*CELL_W, box_y0=row*CELL_H. Use constant multiply or accumulators; results must be exact within 10/9 bits.
- box_x0/box_y0/box_color are registered and held constant from the ISSUE cycle until box_done is accepted, because the renderer adds its offsets combinationally.
- redraw_pending is set by redraw=1 in any cycle and cleared on entering RD from IDLE.
- A redraw arriving during a frame re-arms pending, so exactly one extra frame follows.
- States:
  - IDLE:
    - if redraw_pending or redraw: row=col=0, go RD; a redraw takes priority over a simultaneous upd_valid.
    - else if upd_valid: upd_ready=1 for that cycle; latch row/col/type; go ISSUE with color from upd_type.
  - RD: cell_rd=1, cell_addr=row*COLS+col; go LAT.
  - LAT: capture cell_data into the color register via palette; go ISSUE.
  - ISSUE: box_start=1 for exactly one cycle; go WAIT.
  - WAIT: hold outputs; on box_done go ADV for a full frame, or IDLE for an update.
  - ADV (full frame only):
    - if col<COLS-1: col+1, go RD;
    - else if row<ROWS-1: col=0, row+1, go RD;
    - else: frame_done=1, go IDLE.
- upd_ready is asserted only in IDLE, with no redraw pending and redraw=0.
- box_done outside WAIT is ignored.
- box_done in the same cycle as ISSUE is ignored; the renderer cannot finish that fast.
- Per-cell overhead excluding render time: 4 cycles (RD, LAT, ISSUE, ADV). First box_start comes 3 cycles after redraw is sampled in IDLE.
- Reset mid-operation:
  - immediate return to IDLE;
  - box_start, cell_rd and frame_done drop asynchronously;
  - pending cleared; no partial frame resumes.

Test Plan:
- Reset → all outputs 0, busy=0, upd_ready=0. Release reset with upd_valid=0 → IDLE, busy=0.
- Full redraw: RAM all zeros; renderer model asserts done 10 cycles after start. Pulse redraw → 200 box_start pulses in row-major order; first (0,0), second (64,0), 11th (0,24), last (576,456); all colors 9'h000; one frame_done; busy low after it.
- RAM addr 15=3 → the 16th issue has box_x0=320, box_y0=24, box_color=9'h147. Check cell_rd/cell_addr=15 occur 2 cycles before its box_start.
- Update while idle: upd_valid with col=9, row=19, type=5 → upd_ready for 1 cycle; start with (576,456,9'h1C0); no cell_rd; no frame_done.
- Redraw pulse during the 50th cell of a frame → frame completes, then exactly one more 200-cell frame. A simultaneous upd_valid is held off (upd_ready=0) until both frames finish, then accepted.
- Assert resetn=0 while in WAIT → next cycle busy=0; no further box_start after release until a new request.

Source files
------------

// File: rtl/board_draw_sched_if.sv
// Bundle of request, board-RAM and renderer signals around the draw scheduler.
// The slave modport is the scheduler's view. The master modport is the view of
// the surrounding game logic, board RAM and renderer.
interface board_draw_sched_if #(
  parameter int ADDR_W = 8
);
  logic              redraw;
  logic              upd_valid;
  logic              upd_ready;
  logic [3:0]        upd_col;
  logic [4:0]        upd_row;
  logic [2:0]        upd_type;
  logic [ADDR_W-1:0] cell_addr;
  logic              cell_rd;
  logic [2:0]        cell_data;
  logic              box_start;
  logic [9:0]        box_x0;
  logic [8:0]        box_y0;
  logic [8:0]        box_color;
  logic              box_done;
  logic              busy;
  logic              frame_done;

  modport master (
    output redraw, upd_valid, upd_col, upd_row, upd_type, cell_data, box_done,
    input  upd_ready, cell_addr, cell_rd, box_start, box_x0, box_y0, box_color,
           busy, frame_done
  );

  modport slave (
    input  redraw, upd_valid, upd_col, upd_row, upd_type, cell_data, box_done,
    output upd_ready, cell_addr, cell_rd, box_start, box_x0, box_y0, box_color,
           busy, frame_done
  );
endinterface

// File: rtl/board_draw_sched.sv
// Tetris playfield draw scheduler.
// It walks the board RAM for a full redraw, or paints a single requested cell.
// For each cell it hands the box renderer a start pulse, the cell's top-left
// corner and its palette colour. It then waits for the renderer's done pulse.
module board_draw_sched #(
  parameter int COLS   = 10,
  parameter int ROWS   = 20,
  parameter int CELL_W = 64,
  parameter int CELL_H = 24,
  parameter int ADDR_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  board_draw_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LAT   = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_ADV   = 3'd5
  } state_t;

  localparam logic [3:0] COL_LAST = 4'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  // Cell type to RRR_GGG_BBB colour.
  function automatic logic [8:0] palette(input logic [2:0] cell_type);
    logic [8:0] c;
    case (cell_type)
      3'd0:    c = 9'h000;
      3'd1:    c = 9'h03F;
      3'd2:    c = 9'h1F8;
      3'd3:    c = 9'h147;
      3'd4:    c = 9'h038;
      3'd5:    c = 9'h1C0;
      3'd6:    c = 9'h007;
      3'd7:    c = 9'h1E0;
      default: c = 9'h000;
    endcase
    return c;
  endfunction

  state_t            state, state_n;
  logic [4:0]        row, row_n;
  logic [3:0]        col, col_n;
  logic              is_upd, is_upd_n;
  logic              pending, pending_n;
  logic [8:0]        color, color_n;
  logic              frame_done_n;
  logic              ready;
  logic              cell_rd, box_start, busy, frame_done;
  logic [ADDR_W-1:0] cell_addr;
  logic [9:0]        box_x0;
  logic [8:0]        box_y0;

  // Next-state, counter, pending-flag and colour selection for the sequencer.
  always_comb begin
    state_n      = state;
    row_n        = row;
    col_n        = col;
    is_upd_n     = is_upd;
    pending_n    = pending | bus.redraw;
    color_n      = color;
    frame_done_n = 1'b0;
    ready        = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending || bus.redraw) begin
          // A redraw wins over a simultaneous update, which stays held off.
          row_n     = 5'd0;
          col_n     = 4'd0;
          pending_n = 1'b0;
          is_upd_n  = 1'b0;
          state_n   = S_RD;
        end else if (bus.upd_valid && resetn) begin
          ready    = 1'b1;
          row_n    = bus.upd_row;
          col_n    = bus.upd_col;
          is_upd_n = 1'b1;
          color_n  = palette(bus.upd_type);
          state_n  = S_ISSUE;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_RD: begin
        state_n = S_LAT;
      end
      S_LAT: begin
        // RAM data is valid in the cycle after the read strobe.
        color_n = palette(bus.cell_data);
        state_n = S_ISSUE;
      end
      S_ISSUE: begin
        // A done pulse arriving together with the start is not acted on.
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.box_done) begin
          state_n = is_upd ? S_IDLE : S_ADV;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_ADV: begin
        if (col < COL_LAST) begin
          col_n   = col + 4'd1;
          state_n = S_RD;
        end else if (row < ROW_LAST) begin
          col_n   = 4'd0;
          row_n   = row + 5'd1;
          state_n = S_RD;
        end else begin
          frame_done_n = 1'b1;
          state_n      = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs. Coordinates follow the counters,
  // and the counters do not move between ISSUE and the accepted done pulse.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      row        <= 5'd0;
      col        <= 4'd0;
      is_upd     <= 1'b0;
      pending    <= 1'b0;
      color      <= 9'd0;
      cell_rd    <= 1'b0;
      box_start  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cell_addr  <= '0;
      box_x0     <= 10'd0;
      box_y0     <= 9'd0;
    end else begin
      state      <= state_n;
      row        <= row_n;
      col        <= col_n;
      is_upd     <= is_upd_n;
      pending    <= pending_n;
      color      <= color_n;
      cell_rd    <= (state_n == S_RD);
      box_start  <= (state_n == S_ISSUE);
      busy       <= (state_n != S_IDLE);
      frame_done <= frame_done_n;
      cell_addr  <= ADDR_W'(row_n) * ADDR_W'(COLS) + ADDR_W'(col_n);
      box_x0     <= 10'(col_n) * 10'(CELL_W);
      box_y0     <= 9'(row_n) * 9'(CELL_H);
    end
  end

  assign bus.upd_ready  = ready;
  assign bus.cell_rd    = cell_rd;
  assign bus.cell_addr  = cell_addr;
  assign bus.box_start  = box_start;
  assign bus.box_x0     = box_x0;
  assign bus.box_y0     = box_y0;
  assign bus.box_color  = color;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;

endmodule
